// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared definitions for the instruction ROM/PC block, the control
//   sequencer and the datapath.
//   Contents:
//     - instruction geometry (opcode width, register-field width, field count)
//     - opcode constants
//     - register / bus-source codes
//     - sequencer state enum
//     - field-extraction helpers for the instruction word {op, rx, ry}
package control_sequencer_pkg;

  localparam int OP_SIZE  = 4;
  localparam int ARG_SIZE = 3;
  localparam int ARG_NUM  = 2;
  localparam int NUM_REGS = 6;
  localparam int ADDR_W   = 4;
  localparam int INSTR_W  = OP_SIZE + ARG_NUM * ARG_SIZE;

  // Opcodes
  localparam logic [OP_SIZE-1:0] OP_LOAD = 4'b0000;
  localparam logic [OP_SIZE-1:0] OP_MOVE = 4'b0001;
  localparam logic [OP_SIZE-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_SIZE-1:0] OP_XOR  = 4'b0011;
  localparam logic [OP_SIZE-1:0] OP_BR   = 4'b1000;

  // Register codes; also used as bus source selects.
  // NA doubles as "external data" on the bus.
  localparam logic [ARG_SIZE-1:0] NA    = 3'b000;
  localparam logic [ARG_SIZE-1:0] R1    = 3'b001;
  localparam logic [ARG_SIZE-1:0] R2    = 3'b010;
  localparam logic [ARG_SIZE-1:0] R3    = 3'b011;
  localparam logic [ARG_SIZE-1:0] R4    = 3'b100;
  localparam logic [ARG_SIZE-1:0] R5    = 3'b101;
  localparam logic [ARG_SIZE-1:0] R6    = 3'b110;
  localparam logic [ARG_SIZE-1:0] REG_G = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    T1     = 3'd2,
    T2     = 3'd3,
    T3     = 3'd4
  } state_t;

  function automatic logic [OP_SIZE-1:0] instr_op(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: OP_SIZE];
  endfunction

  function automatic logic [ARG_SIZE-1:0] instr_rx(input logic [INSTR_W-1:0] w);
    return w[2*ARG_SIZE-1 -: ARG_SIZE];
  endfunction

  function automatic logic [ARG_SIZE-1:0] instr_ry(input logic [INSTR_W-1:0] w);
    return w[ARG_SIZE-1:0];
  endfunction

  // ADD and XOR share the three-cycle A/G sequence.
  function automatic logic is_alu_op(input logic [OP_SIZE-1:0] op);
    return (op == OP_ADD) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/control_sequencer_reg_decoder.sv
// reg_decoder
//   Converts a 3-bit register code into a one-hot register write enable.
//   Code n (1..NUM_REGS) sets bit n-1; codes 000 (external/none) and 111 (G)
//   select no general register and give an all-zero vector.
//   Ports:
//     code   in   ARG_SIZE  register code
//     wr_en  out  NUM_REGS  one-hot write enable (bit i-1 = Ri)
module reg_decoder
  import control_sequencer_pkg::*;
#(
  parameter int CODE_W = ARG_SIZE,
  parameter int N_REGS = NUM_REGS
) (
  input  logic [CODE_W-1:0] code,
  output logic [N_REGS-1:0] wr_en
);

  generate
    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_dec
      assign wr_en[gi] = (code == CODE_W'(gi + 1));
    end
  endgenerate

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Execution-side sequencer for the small accumulator-style datapath.
//   Latches the ROM word in DECODE, then runs it over 1-3 execute cycles
//   (T1..T3), driving register-file, A/G latch and ALU controls, and finally
//   hands the ROM a done pulse (PC+1) or a branch/branchaddress pair.
//   Every output is a register whose value is a function of the state being
//   entered and the IR value held in that state, so nothing from run or
//   instruction reaches an output combinationally.
//   Ports:
//     clk            in   1         system clock, rising edge
//     rst            in   1         asynchronous active-low reset
//     run            in   1         execute when high; halt after current instr when low
//     instruction    in   INSTR_W   current ROM word {op, rx, ry}
//     done           out  1         one-cycle pulse, ROM advances PC
//     branch         out  1         one-cycle pulse, ROM loads PC from branchaddress
//     branchaddress  out  4         branch target
//     busy           out  1         high whenever not IDLE
//     bus_sel        out  3         bus source: 000 ext, 001..110 R1..R6, 111 G
//     reg_wr         out  NUM_REGS  one-hot register write enable
//     a_wr           out  1         load A from bus
//     g_wr           out  1         load G from ALU result
//     alu_op         out  1         0 = A+bus, 1 = A^bus
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OP_W   = OP_SIZE,
  parameter int ARG_W  = ARG_SIZE,
  parameter int N_ARGS = ARG_NUM,
  parameter int N_REGS = NUM_REGS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic [OP_W+N_ARGS*ARG_W-1:0] instruction,
  output logic                        done,
  output logic                        branch,
  output logic [ADDR_W-1:0]           branchaddress,
  output logic                        busy,
  output logic [ARG_W-1:0]            bus_sel,
  output logic [N_REGS-1:0]           reg_wr,
  output logic                        a_wr,
  output logic                        g_wr,
  output logic                        alu_op
);

  state_t               state_reg;
  logic [INSTR_W-1:0]   ir_reg;

  // Write enables for the two places a destination is decoded: the incoming
  // word (entering T1 from DECODE) and the held IR (entering T3).
  logic [N_REGS-1:0]    wr_from_instr;
  logic [N_REGS-1:0]    wr_from_ir;

  logic [OP_SIZE-1:0]   in_op;
  logic [ARG_SIZE-1:0]  in_rx;
  logic [ARG_SIZE-1:0]  in_ry;
  logic [OP_SIZE-1:0]   ir_op;
  logic [ARG_SIZE-1:0]  ir_rx;
  logic [ARG_SIZE-1:0]  ir_ry;

  assign in_op = instr_op(instruction);
  assign in_rx = instr_rx(instruction);
  assign in_ry = instr_ry(instruction);
  assign ir_op = instr_op(ir_reg);
  assign ir_rx = instr_rx(ir_reg);
  assign ir_ry = instr_ry(ir_reg);

  reg_decoder #(.CODE_W(ARG_W), .N_REGS(N_REGS)) u_dec_instr (
    .code  (in_rx),
    .wr_en (wr_from_instr)
  );

  reg_decoder #(.CODE_W(ARG_W), .N_REGS(N_REGS)) u_dec_ir (
    .code  (ir_rx),
    .wr_en (wr_from_ir)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      ir_reg        <= '0;
      done          <= 1'b0;
      branch        <= 1'b0;
      branchaddress <= '0;
      busy          <= 1'b0;
      bus_sel       <= NA;
      reg_wr        <= '0;
      a_wr          <= 1'b0;
      g_wr          <= 1'b0;
      alu_op        <= 1'b0;
    end else begin
      // Pulses and enables default low every cycle; branchaddress holds
      // its last target since the ROM only samples it with branch.
      done    <= 1'b0;
      branch  <= 1'b0;
      bus_sel <= NA;
      reg_wr  <= '0;
      a_wr    <= 1'b0;
      g_wr    <= 1'b0;
      alu_op  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (run) begin
            state_reg <= DECODE;
            busy      <= 1'b1;
          end else begin
            busy      <= 1'b0;
          end
        end

        DECODE: begin
          // The ROM may move on after done, so capture the word now and
          // set up the T1 outputs from it.
          ir_reg    <= instruction;
          state_reg <= T1;
          busy      <= 1'b1;
          case (in_op)
            OP_LOAD: begin
              bus_sel <= NA;
              reg_wr  <= wr_from_instr;
              done    <= 1'b1;
            end
            OP_MOVE: begin
              bus_sel <= in_ry;
              reg_wr  <= wr_from_instr;
              done    <= 1'b1;
            end
            OP_ADD, OP_XOR: begin
              bus_sel <= in_rx;
              a_wr    <= 1'b1;
            end
            OP_BR: begin
              branch        <= 1'b1;
              branchaddress <= instruction[ADDR_W-1:0];
            end
            default: begin
              done <= 1'b1;
            end
          endcase
        end

        T1: begin
          if (is_alu_op(ir_op)) begin
            state_reg <= T2;
            busy      <= 1'b1;
            bus_sel   <= ir_ry;
            alu_op    <= ir_op[0];
            g_wr      <= 1'b1;
          end else begin
            // done/branch was high in T1: fetch next or halt.
            state_reg <= run ? DECODE : IDLE;
            busy      <= run;
          end
        end

        T2: begin
          state_reg <= T3;
          busy      <= 1'b1;
          bus_sel   <= REG_G;
          reg_wr    <= wr_from_ir;
          done      <= 1'b1;
        end

        T3: begin
          state_reg <= run ? DECODE : IDLE;
          busy      <= run;
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed bench for control_sequencer: linear sequence of steps, each
//   output vector checked against hand-computed values with an immediate
//   assertion.
module tb_control_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [9:0]  instruction;
  logic        done;
  logic        branch;
  logic [3:0]  branchaddress;
  logic        busy;
  logic [2:0]  bus_sel;
  logic [5:0]  reg_wr;
  logic        a_wr;
  logic        g_wr;
  logic        alu_op;

  int errors = 0;
  int checks = 0;

  control_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .instruction   (instruction),
    .done          (done),
    .branch        (branch),
    .branchaddress (branchaddress),
    .busy          (busy),
    .bus_sel       (bus_sel),
    .reg_wr        (reg_wr),
    .a_wr          (a_wr),
    .g_wr          (g_wr),
    .alu_op        (alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {done, branch, branchaddress[3:0], busy, bus_sel[2:0],
  //               reg_wr[5:0], a_wr, g_wr, alu_op}
  function automatic logic [18:0] ev(input logic d, input logic b, input logic [3:0] ba,
                                     input logic bz, input logic [2:0] bs, input logic [5:0] rw,
                                     input logic a, input logic g, input logic alu);
    return {d, b, ba, bz, bs, rw, a, g, alu};
  endfunction

  function automatic logic [18:0] obs();
    return {done, branch, branchaddress, busy, bus_sel, reg_wr, a_wr, g_wr, alu_op};
  endfunction

  task automatic chk(input string tag, input logic [18:0] expected);
    logic [18:0] observed;
    observed = obs();
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, observed, expected);
    end
    $display("step %-12s outputs=%05h", tag, observed);
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    run         = 1'b1;
    instruction = {4'b0000, 3'b001, 3'b000};   // LOAD R1
    step();
    step();
    chk("reset", ev(0,0,4'h0,0,3'b000,6'b000000,0,0,0));
    rst = 1'b1;

    // LOAD R1
    step(); chk("ld_decode", ev(0,0,4'h0,1,3'b000,6'b000000,0,0,0));
    step(); chk("ld_t1",     ev(1,0,4'h0,1,3'b000,6'b000001,0,0,0));

    // ADD R1,R2
    instruction = {4'b0010, 3'b001, 3'b010};
    step(); chk("add_decode", ev(0,0,4'h0,1,3'b000,6'b000000,0,0,0));
    step(); chk("add_t1",     ev(0,0,4'h0,1,3'b001,6'b000000,1,0,0));
    step(); chk("add_t2",     ev(0,0,4'h0,1,3'b010,6'b000000,0,1,0));
    step(); chk("add_t3",     ev(1,0,4'h0,1,3'b111,6'b000001,0,0,0));

    // XOR R3,R2 -- ROM word changes during T2, IR must hold
    instruction = {4'b0011, 3'b011, 3'b010};
    step(); chk("xor_decode", ev(0,0,4'h0,1,3'b000,6'b000000,0,0,0));
    step(); chk("xor_t1",     ev(0,0,4'h0,1,3'b011,6'b000000,1,0,0));
    step(); chk("xor_t2",     ev(0,0,4'h0,1,3'b010,6'b000000,0,1,1));
    instruction = {4'b1000, 3'b000, 3'b101};   // BR 5
    step(); chk("xor_t3",     ev(1,0,4'h0,1,3'b111,6'b000100,0,0,0));

    // BR 5
    step(); chk("br_decode",  ev(0,0,4'h0,1,3'b000,6'b000000,0,0,0));
    step(); chk("br_t1",      ev(0,1,4'h5,1,3'b000,6'b000000,0,0,0));
    instruction = {4'b0010, 3'b001, 3'b010};   // ADD R1,R2
    step(); chk("br_next",    ev(0,0,4'h5,1,3'b000,6'b000000,0,0,0));

    // ADD with run dropped during T2
    step(); chk("add2_t1",    ev(0,0,4'h5,1,3'b001,6'b000000,1,0,0));
    step(); chk("add2_t2",    ev(0,0,4'h5,1,3'b010,6'b000000,0,1,0));
    run = 1'b0;
    step(); chk("add2_t3",    ev(1,0,4'h5,1,3'b111,6'b000001,0,0,0));
    step(); chk("halt_idle",  ev(0,0,4'h5,0,3'b000,6'b000000,0,0,0));
    step(); chk("halt_idle2", ev(0,0,4'h5,0,3'b000,6'b000000,0,0,0));

    // Restart, then reset during T2
    run = 1'b1;
    step(); chk("rs_decode",  ev(0,0,4'h5,1,3'b000,6'b000000,0,0,0));
    step(); chk("rs_t1",      ev(0,0,4'h5,1,3'b001,6'b000000,1,0,0));
    step(); chk("rs_t2",      ev(0,0,4'h5,1,3'b010,6'b000000,0,1,0));
    rst = 1'b0;
    #1;
    chk("rst_async",          ev(0,0,4'h0,0,3'b000,6'b000000,0,0,0));
    step(); chk("rst_hold",   ev(0,0,4'h0,0,3'b000,6'b000000,0,0,0));

    // Illegal opcode 0101 -> NOP
    instruction = {4'b0101, 3'b010, 3'b011};
    rst = 1'b1;
    step(); chk("nop_decode", ev(0,0,4'h0,1,3'b000,6'b000000,0,0,0));
    step(); chk("nop_t1",     ev(1,0,4'h0,1,3'b000,6'b000000,0,0,0));

    // MOVE R2,R2 (self-write)
    instruction = {4'b0001, 3'b010, 3'b010};
    step(); chk("mv_decode",  ev(0,0,4'h0,1,3'b000,6'b000000,0,0,0));
    step(); chk("mv_t1",      ev(1,0,4'h0,1,3'b010,6'b000010,0,0,0));

    // LOAD to code 111: no register write, done still pulses
    instruction = {4'b0000, 3'b111, 3'b000};
    step(); chk("ldg_decode", ev(0,0,4'h0,1,3'b000,6'b000000,0,0,0));
    step(); chk("ldg_t1",     ev(1,0,4'h0,1,3'b000,6'b000000,0,0,0));

    // MOVE R6,R5
    instruction = {4'b0001, 3'b110, 3'b101};
    step(); chk("mv6_decode", ev(0,0,4'h0,1,3'b000,6'b000000,0,0,0));
    step(); chk("mv6_t1",     ev(1,0,4'h0,1,3'b101,6'b100000,0,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Execution-side counterpart of the instruction ROM/PC block.
- Consumes the instruction word {op[3:0], rx[2:0], ry[2:0]} presented combinationally by the ROM.
- Sequences each instruction over 1–3 execute cycles, driving register-file, A/G latch and ALU controls onto the shared datapath bus.
- Hands the ROM its done pulse (PC+1) or its branch/branchaddress pair.

Parameters:
- OP_SIZE, 4, opcode width
- ARG_SIZE, 3, register-field width
- ARG_NUM, 2, register fields per instruction
- NUM_REGS, 6, general registers R1..R6 (write-enable vector width)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; high = execute instructions, low = halt after the current instruction
- instruction  in  OP_SIZE+ARG_NUM*ARG_SIZE  current ROM word
- done  out  1  one-cycle pulse; ROM advances PC
- branch  out  1  one-cycle pulse; ROM loads PC from branchaddress
- branchaddress  out  4  branch target
- busy  out  1  high while in any state other than IDLE
- bus_sel  out  3  bus source: 000 = external data, 001..110 = R1..R6, 111 = G
- reg_wr  out  NUM_REGS  one-hot write enable; bit i-1 = Ri
- a_wr  out  1  load A latch from bus
- g_wr  out  1  load G latch from ALU result
- alu_op  out  1  0 = add (A+bus), 1 = xor (A^bus)

Behaviour:
- Reset (rst=0, async) values: state=IDLE, IR=0, done=0, branch=0, branchaddress=0, busy=0, bus_sel=000, reg_wr=0, a_wr=0, g_wr=0, alu_op=0.
- All outputs are Moore: decoded from state and IR only. No combinational path from instruction or run to any output.
- Opcodes: LOAD=0000, MOVE=0001, ADD=0010, XOR=0011, BR=1000. Any other opcode is a NOP.
- IDLE: all enables 0. When run=1, go to DECODE.
- DECODE: on exit, latch instruction into IR. The ROM word may change after done, so execute states use IR only. No enables asserted. Next state is T1.
- T1:
  - LOAD: bus_sel=000, reg_wr[rx-1]=1, done=1.
  - MOVE: bus_sel=ry, reg_wr[rx-1]=1, done=1.
  - ADD/XOR: bus_sel=rx, a_wr=1, then go to T2.
  - BR: branch=1, branchaddress=IR[3:0] ({rx[0],ry}), done=0.
  - NOP: done=1, no enables.
- T2 (ADD/XOR): bus_sel=ry, alu_op=op[0], g_wr=1, then go to T3.
- T3 (ADD/XOR): bus_sel=111, reg_wr[rx-1]=1, done=1.
- After any cycle with done or branch high: go to DECODE if run=1, else IDLE.
- Throughput: LOAD/MOVE/BR/NOP take 2 cycles per instruction; ADD/XOR take 4.
- Destination field 000 or 111 produces reg_wr=0; done still pulses.
- MOVE with rx==ry is legal (self-write).
- done and branch are never high in the same cycle.
- run falling mid-instruction: the instruction completes, including its done/branch pulse, then the block enters IDLE.
- rst asserted mid-instruction: immediate return to reset values. The partial instruction is abandoned; no done pulse.
- PC wrap 15→0 belongs to the ROM; the sequencer is agnostic to it.
- Branch to the current address is a legal tight loop: 2 cycles per iteration.

Decomposition:
- Shared package holds opcode constants (OP_LOAD, OP_MOVE, OP_ADD, OP_XOR, OP_BR), register codes (NA, R1..R6, PC/G=111) and the state enum (IDLE, DECODE, T1, T2, T3).
- The same package is imported by the ROM and the datapath.
- One natural sub-module, reg_decoder: 3-bit code → NUM_REGS one-hot write enable, zero for codes 000 and 111.
- Keep the FSM and output decode in control_sequencer.

Test Plan:
- Reset with run=1, release rst. Expect busy=1 on cycle 1. With word {0000,001,000}, expect bus_sel=000, reg_wr=000001, done=1 on cycle 2.
- ADD {0010,001,010}. Expect three execute cycles in order:
  - T1: bus_sel=001, a_wr=1.
  - T2: bus_sel=010, alu_op=0, g_wr=1.
  - T3: bus_sel=111, reg_wr=000001, done=1.
- No other enables in any of these cycles.
- XOR {0011,011,010}. Expect T2 alu_op=1 and T3 reg_wr=000100. Change instruction during T2; IR-driven outputs must not change.
- BR word {1000,000,101}. Expect branch=1, branchaddress=0101, done=0 for one cycle, then DECODE.
- Drop run during T2 of an ADD. Expect T3 done=1, then busy=0 / IDLE; no further enables until run=1.
- Pull rst low during T2. Expect all outputs 0 immediately, no done pulse. Illegal opcode 0101 yields done=1 with reg_wr=0.
